// File: rtl/ctrl_event_capture.sv
// Stability filter on the synchronized 4-bit control word. Each accepted change is queued as an
// {old, new} event in a first-word fall-through FIFO drained over valid/ready; drops are counted.
module ctrl_event_capture #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                          clkB,
  input  logic                          rstB,
  input  logic [3:0]                    ctrl_in,
  input  logic                          evt_ready,
  input  logic                          clr_ovf,
  output logic                          evt_valid,
  output logic [7:0]                    evt_data,
  output logic [3:0]                    ctrl_stable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  RunMax = 4'(STABLE_CYCLES);
  localparam logic [3:0]  RunAcc = 4'(STABLE_CYCLES - 1);
  localparam logic [AW:0] Depth  = (AW + 1)'(FIFO_DEPTH);

  // Filter state
  logic [3:0] last_q, last_d;
  logic [3:0] run_q, run_d;
  logic [3:0] stable_q, stable_d;
  logic       same;
  logic       accept;

  // Queue state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [AW:0]   level;
  logic          full;
  logic          not_empty;
  logic          pop;
  logic          push;
  logic          drop;

  // Drop accounting
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;

  // Stability filter: run_q counts consecutive identical samples ending at the previous edge.
  always_comb begin
    same   = (ctrl_in == last_q);
    last_d = ctrl_in;
    run_d  = run_q;
    if (!same) begin
      run_d = 4'd1;
    end else if (run_q < RunMax) begin
      run_d = run_q + 4'd1;
    end
    accept   = same && (run_q == RunAcc) && (last_q != stable_q);
    stable_d = accept ? last_q : stable_q;
  end

  always_comb begin
    level     = wr_q - rd_q;
    full      = (level == Depth);
    not_empty = (wr_q != rd_q);
    pop       = not_empty && evt_ready;
    // A pop on a full queue frees the head slot in time for the same-edge push.
    push      = accept && (!full || pop);
    drop      = accept && full && !pop;
    wr_d      = push ? wr_q + 1'b1 : wr_q;
    rd_d      = pop ? rd_q + 1'b1 : rd_q;
  end

  // A drop on the same edge as a clear wins, leaving a count of one.
  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf) begin
        drop_d = CNT_W'(1);
      end else if (!(&drop_q)) begin
        drop_d = drop_q + CNT_W'(1);
      end
    end else if (clr_ovf) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge clkB) begin
    if (!rstB) begin
      last_q   <= '0;
      run_q    <= RunMax;
      stable_q <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      last_q   <= last_d;
      run_q    <= run_d;
      stable_q <= stable_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clkB) begin
    if (rstB && push) begin
      mem_q[wr_q[AW-1:0]] <= {stable_q, last_q};
    end
  end

  // Head is gated so the data bus reads zero whenever the queue is empty.
  always_comb begin
    evt_valid   = not_empty;
    evt_data    = not_empty ? mem_q[rd_q[AW-1:0]] : 8'h00;
    ctrl_stable = stable_q;
    fifo_level  = level;
    drop_cnt    = drop_q;
    overflow    = ovf_q;
  end

endmodule

// File: tb/tb_ctrl_event_capture.sv
// Randomized and directed bench for ctrl_event_capture against a queue-based reference model.
module tb_ctrl_event_capture;

  localparam int unsigned S     = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;
  localparam int          MAXD  = (1 << CW) - 1;

  logic                   clkB = 1'b0;
  logic                   rstB;
  logic [3:0]             ctrl_in;
  logic                   evt_ready;
  logic                   clr_ovf;
  logic                   evt_valid;
  logic [7:0]             evt_data;
  logic [3:0]             ctrl_stable;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CW-1:0]          drop_cnt;
  logic                   overflow;

  int vectors     = 0;
  int miscompares = 0;

  ctrl_event_capture #(
    .STABLE_CYCLES(S),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (CW)
  ) dut (
    .clkB       (clkB),
    .rstB       (rstB),
    .ctrl_in    (ctrl_in),
    .evt_ready  (evt_ready),
    .clr_ovf    (clr_ovf),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .ctrl_stable(ctrl_stable),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow)
  );

  always #5 clkB = ~clkB;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accept when the last S samples all equal a value differing from the
  // accepted one; the history is primed with zeros at reset.
  logic [3:0] hist[$];
  logic [3:0] m_stable = 4'h0;
  logic [7:0] m_q[$];
  int         m_drop = 0;
  bit         m_ovf = 1'b0;
  bit         model_ok = 1'b0;

  always @(posedge clkB) begin
    bit acc;
    bit drop_now;
    if (!rstB) begin
      hist.delete();
      for (int i = 0; i < S; i++) hist.push_back(4'h0);
      m_stable = 4'h0;
      m_q.delete();
      m_drop   = 0;
      m_ovf    = 1'b0;
      model_ok = 1'b1;
    end else begin
      hist.push_back(ctrl_in);
      if (hist.size() > S) void'(hist.pop_front());
      acc = (ctrl_in != m_stable);
      foreach (hist[i]) if (hist[i] != ctrl_in) acc = 1'b0;
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      drop_now = 1'b0;
      if (acc) begin
        if (m_q.size() < DEPTH) m_q.push_back({m_stable, ctrl_in});
        else drop_now = 1'b1;
        m_stable = ctrl_in;
      end
      if (clr_ovf) begin
        m_drop = 0;
        m_ovf  = 1'b0;
      end
      if (drop_now) begin
        if (m_drop < MAXD) m_drop++;
        m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clkB) begin
    if (model_ok) begin
      chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("evt_data", 32'(evt_data), 32'(m_q[0]));
      chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      chk("ctrl_stable", 32'(ctrl_stable), 32'(m_stable));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clkB);
    #1;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    ctrl_in = v;
    step(n);
  endtask

  initial begin
    int   hold_left;
    int   ready_pct;
    logic [3:0] rv;

    rstB      = 1'b0;
    ctrl_in   = 4'hA;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;

    // Reset release
    step(2);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_data", 32'(evt_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_stable", 32'(ctrl_stable), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rstB = 1'b1;
    step(2);
    chk("pre_accept_stable", 32'(ctrl_stable), 32'h0);
    step(1);
    chk("rel_stable", 32'(ctrl_stable), 32'hA);
    chk("rel_valid", 32'(evt_valid), 32'd1);
    chk("rel_data", 32'(evt_data), 32'h0A);

    // Glitch rejection
    evt_ready = 1'b1;
    hold(4'h0, 6);
    chk("drain_level", 32'(fifo_level), 32'd0);
    hold(4'h5, 2);
    hold(4'h0, 4);
    chk("glitch_stable", 32'(ctrl_stable), 32'h0);
    chk("glitch_valid", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;
    hold(4'h5, 3);
    chk("accept5_valid", 32'(evt_valid), 32'd1);
    chk("accept5_data", 32'(evt_data), 32'h05);
    evt_ready = 1'b1;
    hold(4'h0, 5);

    // Backpressure and overflow
    evt_ready = 1'b0;
    for (int v = 1; v <= 5; v++) hold(4'(v), 4);
    chk("bp_level", 32'(fifo_level), 32'd4);
    chk("bp_drop", 32'(drop_cnt), 32'd1);
    chk("bp_ovf", 32'(overflow), 32'd1);
    chk("bp_stable", 32'(ctrl_stable), 32'h5);
    evt_ready = 1'b1;
    chk("bp_pop0", 32'(evt_data), 32'h01);
    step(1);
    chk("bp_pop1", 32'(evt_data), 32'h12);
    step(1);
    chk("bp_pop2", 32'(evt_data), 32'h23);
    step(1);
    chk("bp_pop3", 32'(evt_data), 32'h34);
    step(1);
    chk("bp_empty", 32'(evt_valid), 32'd0);

    // Full queue, push and pop on the same edge
    evt_ready = 1'b0;
    for (int v = 6; v <= 9; v++) hold(4'(v), 4);
    chk("full_level", 32'(fifo_level), 32'd4);
    hold(4'hA, 2);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("pp_level", 32'(fifo_level), 32'd4);
    chk("pp_drop", 32'(drop_cnt), 32'd1);
    chk("pp_head", 32'(evt_data), 32'h67);
    evt_ready = 1'b1;
    step(3);
    chk("pp_tail", 32'(evt_data), 32'h9A);
    step(1);
    chk("pp_empty", 32'(evt_valid), 32'd0);

    // Clear versus drop on the same edge
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    evt_ready = 1'b0;
    hold(4'hB, 4); hold(4'hC, 4); hold(4'hD, 4); hold(4'hE, 4);
    hold(4'hF, 4); hold(4'h1, 4); hold(4'h2, 4);
    chk("pre_clr_drop", 32'(drop_cnt), 32'd3);
    hold(4'h3, 2);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("clrdrop_ovf", 32'(overflow), 32'd1);
    chk("clrdrop_cnt", 32'(drop_cnt), 32'd1);
    clr_ovf = 1'b1;
    step(1);
    clr_ovf = 1'b0;
    chk("clr2_cnt", 32'(drop_cnt), 32'd0);

    // Mid-operation reset
    evt_ready = 1'b1;
    step(5);
    evt_ready = 1'b0;
    hold(4'h4, 4); hold(4'h5, 4); hold(4'h6, 4);
    hold(4'h7, 1);
    chk("mid_level", 32'(fifo_level), 32'd3);
    rstB    = 1'b0;
    ctrl_in = 4'h0;
    step(1);
    rstB = 1'b1;
    chk("mid_valid", 32'(evt_valid), 32'd0);
    chk("mid_level0", 32'(fifo_level), 32'd0);
    chk("mid_stable", 32'(ctrl_stable), 32'h0);
    step(6);
    chk("mid_nostale", 32'(evt_valid), 32'd0);

    // Drop counter saturation
    for (int i = 0; i < 264; i++) hold((i % 2 == 1) ? 4'h2 : 4'h1, 3);
    chk("sat_drop", 32'(drop_cnt), 32'(MAXD));
    chk("sat_ovf", 32'(overflow), 32'd1);

    // Randomized traffic
    hold_left = 0;
    ready_pct = 50;
    rv        = 4'h0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) ready_pct = $urandom_range(0, 100);
      if (hold_left == 0) begin
        rv        = 4'($urandom_range(0, 3));
        hold_left = $urandom_range(1, 5);
      end
      hold_left--;
      ctrl_in   = rv;
      evt_ready = ($urandom_range(0, 99) < ready_pct);
      clr_ovf   = ($urandom_range(0, 49) == 0);
      rstB      = ($urandom_range(0, 999) != 0);
      step(1);
    end
    rstB = 1'b1;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_event_capture.md
# ctrl_event_capture

Receive-side consumer of the 4-bit control word after it has been brought into the clkB domain by the double-flop synchronizer. The synchronized bus can show transient mixed-bit codes while it settles. This block applies a stability filter, tracks the accepted control value and turns every accepted change into an event. Events are queued in a small FIFO and drained by clkB-domain logic over a valid/ready handshake, with drops counted when the queue is full.

## Interface
- STABLE_CYCLES, 3: consecutive identical samples needed to accept a value; legal range 2..15.
- FIFO_DEPTH, 4: event queue depth; must be a power of two, at least 2.
- CNT_W, 8: width of the drop counter.

Ports:
- clkB  in  1  sole clock; all logic is on its rising edge.
- rstB  in  1  reset; synchronous and active-low.
- ctrl_in  in  4  synchronized control word from the synchronizer output.
- evt_ready  in  1  consumer can accept the head event.
- clr_ovf  in  1  single-cycle clear of overflow and drop_cnt.
- evt_valid  out  1  FIFO holds at least one event.
- evt_data  out  8  head event, {old_value[3:0], new_value[3:0]}.
- ctrl_stable  out  4  currently accepted control value.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued events.
- drop_cnt  out  CNT_W  events lost to a full FIFO; saturates at all-ones.
- overflow  out  1  sticky flag: at least one event dropped since last clear.

## Operation
- Reset: on any edge with rstB=0, the following clear synchronously; ctrl_in, evt_ready and clr_ovf are ignored during reset.
  - ctrl_stable=0, last_sample=0, run_cnt=STABLE_CYCLES (saturated).
  - FIFO pointers=0; evt_valid=0, evt_data=0, fifo_level=0, drop_cnt=0, overflow=0.
  - Reset mid-operation discards every queued event.
- Stability filter, each edge:
  - ctrl_in!=last_sample: last_sample<=ctrl_in, run_cnt<=1.
  - Otherwise run_cnt increments, saturating at STABLE_CYCLES.
- Accept condition: ctrl_in==last_sample, run_cnt==STABLE_CYCLES-1 and last_sample!=ctrl_stable.
- On accept:
  - ctrl_stable<=last_sample.
  - Push {ctrl_stable(old), last_sample} into the FIFO.
- A value that goes unstable and returns to ctrl_stable produces no event.
- FIFO:
  - First-word fall-through: evt_data is the head entry whenever evt_valid=1. evt_data is don't-care when evt_valid=0; it reads 0 after reset.
  - Pop happens on an edge with evt_valid & evt_ready.
  - Push and pop on the same edge are both performed, including when full; fifo_level is unchanged.
  - Push while full with no pop: the event is dropped, drop_cnt increments (saturating) and overflow<=1.
  - ctrl_stable still updates on a drop.
  - Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
- Clear: clr_ovf=1 sets overflow<=0 and drop_cnt<=0. If a drop happens on the same edge, the drop wins: overflow=1, drop_cnt=1.

## Timing
- ctrl_in presents a new value V from edge t onward. V is sampled at edges t..t+STABLE_CYCLES-1.
- ctrl_stable=V and the pushed event are visible after edge t+STABLE_CYCLES-1.
- Push into an empty FIFO: evt_valid rises in the cycle after the push edge, so latency is STABLE_CYCLES edges from first sample.
- Back-to-back pops run at one per cycle while evt_ready=1.
- fifo_level updates on the same edge as the push/pop.
- drop_cnt and overflow update on the edge of the dropped push.
- All outputs are registered or derived only from registers; there is no combinational path from any input to any output.

## Test plan
- Reset release:
  - Stimulus: hold rstB=0 for 2 cycles with ctrl_in=4'hA, then release.
  - Required: all outputs 0 while in reset; ctrl_stable=4'hA after the 3rd sampling edge; evt_valid=1 with evt_data=8'h0A on the next cycle.
- Glitch rejection (STABLE_CYCLES=3):
  - Stimulus: ctrl_in goes 0 -> 5 for 2 cycles -> back to 0.
  - Required: no event, ctrl_stable=0 throughout.
  - Stimulus: 0 -> 5 for 3 cycles.
  - Required: one event, 8'h05.
- Backpressure and overflow:
  - Stimulus: evt_ready=0; stable sequence 1, 2, 3, 4, 5, each held 4 cycles.
  - Required: fifo_level=4; queue holds 8'h01, 12, 23, 34; drop_cnt=1; overflow=1; ctrl_stable=5.
  - Stimulus: then evt_ready=1.
  - Required: 01, 12, 23, 34 pop on consecutive cycles; evt_valid=0 afterwards.
- Full FIFO, simultaneous push/pop:
  - Stimulus: accept edge coincides with a pop while fifo_level=4.
  - Required: fifo_level stays 4, drop_cnt unchanged, new event appears at the tail.
- Clear vs. drop on the same edge:
  - Stimulus: clr_ovf=1 on the same edge as a dropped push, with drop_cnt=3 beforehand.
  - Required: overflow=1, drop_cnt=1.
- Mid-operation reset:
  - Stimulus: rstB=0 for 1 cycle with fifo_level=3 and a filter count in progress.
  - Required: next cycle evt_valid=0, fifo_level=0, ctrl_stable=0, and no stale event after release.
